// File: rtl/axis_pkt_checker_pkg.sv
// rtl/axis_pkt_checker_pkg.sv - shared types for the AXIS packet pattern checker
// Holds the per-channel state enum, the error-code enum, the back-pressure
// generator state enum and the per-channel context struct.
package axis_pkt_checker_pkg;

    localparam int BYTE_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IN_PKT = 2'd1,
        ST_DROP   = 2'd2
    } chan_state_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_SEQ      = 3'd1,
        ERR_DATA     = 3'd2,
        ERR_KEEP     = 3'd3,
        ERR_OVERSIZE = 3'd4,
        ERR_BAD_DEST = 3'd5
    } err_code_e;

    typedef enum logic {
        BP_READY = 1'b0,
        BP_STALL = 1'b1
    } bp_state_e;

    // exp_byte is the value the next payload byte must carry; err latches the
    // first error seen in the packet so later beats cannot overwrite it.
    typedef struct packed {
        chan_state_e           state;
        logic [BYTE_CNT_W-1:0] byte_cnt;
        logic [7:0]            seq;
        logic [7:0]            exp_byte;
        err_code_e             err;
    } chan_ctx_t;

endpackage

// File: rtl/axis_int.sv
// rtl/axis_int.sv - AXI-Stream style bundle carrying tdata/tkeep/tdest/tlast
// Master drives payload and handshake valid; Slave drives tready.
interface AXIS_int #(
    parameter int DATA_BYTES = 8,
    parameter int DEST_WIDTH = 4
);
    logic [DATA_BYTES*8-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic [DEST_WIDTH-1:0]   tdest;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport Master (output tdata, tkeep, tdest, tvalid, tlast, input tready);
    modport Slave  (input tdata, tkeep, tdest, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_pkt_checker_bp_gen.sv
// rtl/axis_pkt_checker_bp_gen.sv - LFSR driven tready stall generator
// Ports: clk, sresetn (sync active-low), max_bp_cycles (longest stall run,
// 0 disables stalls), ready (1 = accept).
module axis_pkt_checker_bp_gen
    import axis_pkt_checker_pkg::*;
(
    input  logic       clk,
    input  logic       sresetn,
    input  logic [7:0] max_bp_cycles,
    output logic       ready
);

    logic [15:0] lfsr_q, lfsr_d;
    bp_state_e   state_q, state_d;
    logic [7:0]  run_q, run_d;
    logic [7:0]  run_len;

    always_comb begin
        // x^16 + x^14 + x^13 + x^11, right-shifting Fibonacci form
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

        // Clamp the random candidate into 1..max_bp_cycles
        if (lfsr_q[15:8] == 8'd0) begin
            run_len = 8'd1;
        end else if (lfsr_q[15:8] > max_bp_cycles) begin
            run_len = max_bp_cycles;
        end else begin
            run_len = lfsr_q[15:8];
        end

        state_d = state_q;
        run_d   = run_q;
        ready   = 1'b1;
        case (state_q)
            BP_READY: begin
                if (max_bp_cycles != 8'd0 && lfsr_q[1:0] == 2'b00) begin
                    state_d = BP_STALL;
                    run_d   = run_len;
                end
            end
            BP_STALL: begin
                ready = 1'b0;
                if (run_q <= 8'd1 || max_bp_cycles == 8'd0) begin
                    state_d = BP_READY;
                end else begin
                    run_d = run_q - 8'd1;
                end
            end
            default: state_d = BP_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            lfsr_q  <= 16'hACE1;
            state_q <= BP_READY;
            run_q   <= 8'd0;
        end else begin
            lfsr_q  <= lfsr_d;
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

endmodule

// File: rtl/axis_pkt_pattern_checker.sv
// rtl/axis_pkt_pattern_checker.sv - per-TDEST incrementing-byte packet checker
// Ports: clk, sresetn (sync active-low), axis_in (stream under test, Slave),
// clear_stats, stat_sel -> stat_good_cnt/stat_err_cnt (registered),
// err_valid/err_dest/err_code (error report pulse), max_bp_cycles.
// Option: define AXIS_PKT_CHECKER_BP_EN to add LFSR back-pressure on tready.
module axis_pkt_pattern_checker
    import axis_pkt_checker_pkg::*;
#(
    parameter int DATA_BYTES   = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int MTU_BYTES    = 1500,
    parameter int CNT_WIDTH    = 32,
    parameter int DEST_WIDTH   = 4,
    localparam int SEL_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  sresetn,
    AXIS_int.Slave                axis_in,
    input  logic                  clear_stats,
    input  logic [SEL_W-1:0]      stat_sel,
    output logic [CNT_WIDTH-1:0]  stat_good_cnt,
    output logic [CNT_WIDTH-1:0]  stat_err_cnt,
    output logic                  err_valid,
    output logic [DEST_WIDTH-1:0] err_dest,
    output logic [2:0]            err_code,
    input  logic [7:0]            max_bp_cycles
);

    chan_ctx_t              ctx_q [NUM_CHANNELS];
    chan_ctx_t              ctx_d [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]   good_cnt_q [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]   good_cnt_d [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]   err_cnt_q [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]   err_cnt_d [NUM_CHANNELS];
    logic [CNT_WIDTH-1:0]   stat_good_q, stat_good_d, stat_err_q, stat_err_d;
    logic                   err_valid_q, err_valid_d;
    logic [DEST_WIDTH-1:0]  err_dest_q, err_dest_d;
    logic [2:0]             err_code_q, err_code_d;
    logic [NUM_CHANNELS-1:0] good_inc, err_inc;

    logic            hs, bad_dest, keep_ok, data_ok;
    logic [SEL_W-1:0] ch;
    chan_ctx_t       cur, nxt;
    logic [7:0]      base;
    logic [16:0]     n_bytes, cnt_sum;
    err_code_e       beat_err;

`ifdef AXIS_PKT_CHECKER_BP_EN
    logic bp_ready;
    axis_pkt_checker_bp_gen u_bp_gen (
        .clk          (clk),
        .sresetn      (sresetn),
        .max_bp_cycles(max_bp_cycles),
        .ready        (bp_ready)
    );
    assign axis_in.tready = sresetn & bp_ready;
`else
    logic unused_max_bp;
    assign unused_max_bp  = ^max_bp_cycles;
    assign axis_in.tready = sresetn;
`endif

    assign hs       = axis_in.tvalid & axis_in.tready;
    assign bad_dest = int'(axis_in.tdest) >= NUM_CHANNELS;
    assign ch       = axis_in.tdest[SEL_W-1:0];
    // Contiguous from byte 0, non-empty, and only the last beat may be short
    assign keep_ok  = (axis_in.tkeep != '0)
                   && ((axis_in.tkeep & (axis_in.tkeep + DATA_BYTES'(1))) == '0)
                   && (axis_in.tlast || (&axis_in.tkeep));

    always_comb begin
        ctx_d       = ctx_q;
        good_inc    = '0;
        err_inc     = '0;
        err_valid_d = 1'b0;
        err_dest_d  = err_dest_q;
        err_code_d  = err_code_q;
        cur         = ctx_q[ch];
        nxt         = cur;
        n_bytes     = '0;
        data_ok     = 1'b1;
        // A first beat defines its own reference so a bad first byte only
        // raises SEQ and the rest of the packet is checked against it.
        base = (cur.state == ST_IDLE) ? axis_in.tdata[7:0] : cur.exp_byte;
        for (int k = 0; k < DATA_BYTES; k++) begin
            n_bytes = n_bytes + {16'd0, axis_in.tkeep[k]};
            if (axis_in.tkeep[k] && (axis_in.tdata[8*k +: 8] != base + 8'(k))) begin
                data_ok = 1'b0;
            end
        end
        cnt_sum = ((cur.state == ST_IDLE) ? 17'd0 : {1'b0, cur.byte_cnt}) + n_bytes;

        beat_err = ERR_NONE;
        if (cur.state == ST_IDLE && axis_in.tdata[7:0] != cur.seq) begin
            beat_err = ERR_SEQ;
        end else if (cur.state != ST_DROP) begin
            if (!data_ok)                        beat_err = ERR_DATA;
            else if (!keep_ok)                   beat_err = ERR_KEEP;
            else if (cnt_sum > 17'(MTU_BYTES))   beat_err = ERR_OVERSIZE;
        end

        if (hs && bad_dest) begin
            if (axis_in.tlast) begin
                err_valid_d = 1'b1;
                err_dest_d  = axis_in.tdest;
                err_code_d  = ERR_BAD_DEST;
            end
        end else if (hs) begin
            if (cur.state == ST_IDLE) begin
                // Taking seq from the received byte covers both the normal
                // increment and resynchronisation after a SEQ error.
                nxt.seq = axis_in.tdata[7:0] + 8'd1;
                nxt.err = beat_err;
            end else if (cur.err == ERR_NONE) begin
                nxt.err = beat_err;
            end
            nxt.exp_byte = base + n_bytes[7:0];
            nxt.byte_cnt = cnt_sum[16] ? '1 : cnt_sum[15:0];
            if (axis_in.tlast)                                        nxt.state = ST_IDLE;
            else if (cur.state == ST_DROP || cnt_sum > 17'(MTU_BYTES)) nxt.state = ST_DROP;
            else                                                      nxt.state = ST_IN_PKT;

            if (axis_in.tlast) begin
                if (nxt.err != ERR_NONE) begin
                    err_inc[ch] = 1'b1;
                    err_valid_d = 1'b1;
                    err_dest_d  = axis_in.tdest;
                    err_code_d  = nxt.err;
                end else begin
                    good_inc[ch] = 1'b1;
                end
            end
            ctx_d[ch] = nxt;
        end
    end

    always_comb begin
        stat_good_d = '0;
        stat_err_d  = '0;
        for (int d = 0; d < NUM_CHANNELS; d++) begin
            good_cnt_d[d] = good_cnt_q[d];
            err_cnt_d[d]  = err_cnt_q[d];
            if (clear_stats) begin
                good_cnt_d[d] = '0;
                err_cnt_d[d]  = '0;
            end else begin
                if (good_inc[d] && !(&good_cnt_q[d])) good_cnt_d[d] = good_cnt_q[d] + 1'b1;
                if (err_inc[d] && !(&err_cnt_q[d]))   err_cnt_d[d]  = err_cnt_q[d] + 1'b1;
            end
            if (SEL_W'(d) == stat_sel) begin
                stat_good_d = good_cnt_q[d];
                stat_err_d  = err_cnt_q[d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!sresetn) begin
            ctx_q       <= '{default: '0};
            good_cnt_q  <= '{default: '0};
            err_cnt_q   <= '{default: '0};
            stat_good_q <= '0;
            stat_err_q  <= '0;
            err_valid_q <= 1'b0;
            err_dest_q  <= '0;
            err_code_q  <= '0;
        end else begin
            ctx_q       <= ctx_d;
            good_cnt_q  <= good_cnt_d;
            err_cnt_q   <= err_cnt_d;
            stat_good_q <= stat_good_d;
            stat_err_q  <= stat_err_d;
            err_valid_q <= err_valid_d;
            err_dest_q  <= err_dest_d;
            err_code_q  <= err_code_d;
        end
    end

    assign stat_good_cnt = stat_good_q;
    assign stat_err_cnt  = stat_err_q;
    assign err_valid     = err_valid_q;
    assign err_dest      = err_dest_q;
    assign err_code      = err_code_q;

endmodule

// File: tb/tb_axis_pkt_pattern_checker.sv
// tb/tb_axis_pkt_pattern_checker.sv - randomized self-checking bench for axis_pkt_pattern_checker
module tb_axis_pkt_pattern_checker;

    localparam int NCH = 4;
    localparam int MTU = 1500;
    localparam int DB  = 8;
    localparam int DW  = 4;
    localparam int CW  = 32;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        int          dest;
        bit          last;
        int          code;
    } beat_t;

    logic          clk = 1'b0;
    logic          sresetn = 1'b0;
    logic          clear_stats = 1'b0;
    logic [1:0]    stat_sel = 2'd0;
    logic [CW-1:0] stat_good_cnt, stat_err_cnt;
    logic          err_valid;
    logic [DW-1:0] err_dest;
    logic [2:0]    err_code;
    logic [7:0]    max_bp_cycles = 8'd4;

    AXIS_int #(.DATA_BYTES(DB), .DEST_WIDTH(DW)) axis_if ();

    axis_pkt_pattern_checker #(
        .DATA_BYTES(DB), .NUM_CHANNELS(NCH), .MTU_BYTES(MTU), .CNT_WIDTH(CW), .DEST_WIDTH(DW)
    ) dut (
        .clk(clk), .sresetn(sresetn), .axis_in(axis_if), .clear_stats(clear_stats),
        .stat_sel(stat_sel), .stat_good_cnt(stat_good_cnt), .stat_err_cnt(stat_err_cnt),
        .err_valid(err_valid), .err_dest(err_dest), .err_code(err_code),
        .max_bp_cycles(max_bp_cycles)
    );

    always #5 clk = ~clk;

    int    n_tests = 0, n_fail = 0;
    int    exp_seq [NCH];
    int    exp_good [NCH];
    int    exp_err [NCH];
    int    exp_pulses = 0, seen_pulses = 0;
    int    run_cur = 0, run_max = 0;
    bit    clear_on_last = 0;
    beat_t qa [$];
    beat_t qb [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (err_valid === 1'b1) seen_pulses++;
        if (sresetn && axis_if.tready !== 1'b1) begin
            run_cur++;
            if (run_cur > run_max) run_max = run_cur;
        end else begin
            run_cur = 0;
        end
    end

    // Expected outcome of a whole packet; faults are injected one at a time.
    function automatic int model_code(input int dest, input int len, input int first,
                                      input int bad_idx, input int part0);
        if (dest >= NCH)                    return 5;
        if (first != exp_seq[dest])         return 1;
        if (bad_idx >= 1 && bad_idx < len)  return 2;
        if (part0 > 0 && len > DB)          return 3;
        if (len > MTU)                      return 4;
        return 0;
    endfunction

    task automatic add_pkt(input int slot, input int dest, input int len, input int first,
                           input int bad_idx, input int part0);
        beat_t      b;
        int         k, n, code;
        logic [7:0] bv;
        code = model_code(dest, len, first, bad_idx, part0);
        if (dest < NCH) exp_seq[dest] = (first + 1) % 256;
        k = 0;
        while (k < len) begin
            n = (len - k > DB) ? DB : len - k;
            if (k == 0 && part0 > 0 && len > DB) n = part0;
            b.data = {$urandom, $urandom};
            b.keep = '0;
            for (int i = 0; i < n; i++) begin
                bv = 8'(first + k + i);
                if (k + i == bad_idx) bv = bv ^ 8'h5a;
                b.data[8*i +: 8] = bv;
                b.keep[i] = 1'b1;
            end
            b.dest = dest;
            k += n;
            b.last = (k >= len);
            b.code = b.last ? code : -1;
            if (slot == 0) qa.push_back(b); else qb.push_back(b);
        end
    endtask

    task automatic drive(input beat_t b);
        bit done = 0;
        axis_if.tdata  = b.data;
        axis_if.tkeep  = b.keep;
        axis_if.tdest  = 4'(b.dest);
        axis_if.tlast  = b.last;
        axis_if.tvalid = 1'b1;
        if (b.last && clear_on_last) clear_stats = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            done = (axis_if.tready === 1'b1);
            @(posedge clk);
            #1;
        end
        axis_if.tvalid = 1'b0;
        clear_stats    = 1'b0;
        if (!done) begin
            check_eq("handshake_timeout", 0, 1);
            return;
        end
        if (b.last) begin
            check_eq("err_valid_eop", err_valid, b.code != 0);
            if (b.code != 0) begin
                check_eq("err_dest", err_dest, b.dest);
                check_eq("err_code", err_code, b.code);
                exp_pulses++;
            end
            if (clear_on_last) begin
                for (int d = 0; d < NCH; d++) begin exp_good[d] = 0; exp_err[d] = 0; end
            end else if (b.dest < NCH) begin
                if (b.code == 0) exp_good[b.dest]++; else exp_err[b.dest]++;
            end
        end else begin
            check_eq("err_valid_mid", err_valid, 0);
        end
        repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    endtask

    task automatic run_slots(input bit alt);
        bit turn_a = 1;
        while (qa.size() > 0 || qb.size() > 0) begin
            if (qa.size() > 0 && (qb.size() == 0 || (alt ? turn_a : bit'($urandom_range(0, 1)))))
                drive(qa.pop_front());
            else
                drive(qb.pop_front());
            turn_a = !turn_a;
        end
    endtask

    task automatic read_stats(input int d);
        stat_sel = 2'(d);
        repeat (2) @(posedge clk);
        #1;
        check_eq($sformatf("good_cnt[%0d]", d), stat_good_cnt, exp_good[d]);
        check_eq($sformatf("err_cnt[%0d]", d), stat_err_cnt, exp_err[d]);
    endtask

    task automatic reset_dut();
        sresetn = 1'b0;
        axis_if.tvalid = 1'b0;
        clear_stats = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tready", axis_if.tready, 0);
        check_eq("rst_err_valid", err_valid, 0);
        check_eq("rst_err_dest", err_dest, 0);
        check_eq("rst_err_code", err_code, 0);
        for (int d = 0; d < NCH; d++) begin exp_seq[d] = 0; exp_good[d] = 0; exp_err[d] = 0; end
        qa.delete();
        qb.delete();
        sresetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic gen_pkt(input int slot, input int avoid, output int dest);
        int r, len, first, bad, part;
        r = $urandom_range(0, 99);
        len = $urandom_range(1, 120);
        bad = -1;
        part = 0;
        do dest = $urandom_range(0, NCH - 1); while (dest == avoid);
        first = exp_seq[dest];
        if (r < 8) begin
            dest = $urandom_range(NCH, 15);
            first = $urandom_range(0, 255);
        end else if (r < 16) begin
            first = int'((exp_seq[dest] + $urandom_range(1, 255)) % 256);
        end else if (r < 24) begin
            if (len < 2) len = 2;
            bad = $urandom_range(1, len - 1);
        end else if (r < 32) begin
            if (len < DB + 1) len = DB + 1;
            part = $urandom_range(1, DB - 1);
        end else if (r < 34) begin
            len = $urandom_range(MTU + 1, MTU + 100);
        end else if (r < 36) begin
            len = $urandom_range(MTU - 16, MTU);
        end
        add_pkt(slot, dest, len, first, bad, part);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int da, db;
        axis_if.tvalid = 1'b0;
        axis_if.tdata  = '0;
        axis_if.tkeep  = '0;
        axis_if.tdest  = '0;
        axis_if.tlast  = 1'b0;

        reset_dut();
        for (int d = 0; d < NCH; d++) read_stats(d);

        // three clean 64-byte packets on channel 0
        for (int i = 0; i < 3; i++) begin add_pkt(0, 0, 64, i, -1, 0); run_slots(0); end
        read_stats(0);

        // corrupted byte 10 on channel 1, then a clean packet
        add_pkt(0, 1, 100, 0, 10, 0); run_slots(0);
        add_pkt(0, 1, 100, 1, -1, 0); run_slots(0);
        read_stats(1);

        // sequence jump on channel 2 and resynchronisation
        add_pkt(0, 2, 50, 5, -1, 0); run_slots(0);
        add_pkt(0, 2, 50, 6, -1, 0); run_slots(0);
        read_stats(2);

        // oversize on channel 0 interleaved beat by beat with channel 3
        add_pkt(0, 0, 1600, exp_seq[0], -1, 0);
        add_pkt(1, 3, 200, exp_seq[3], -1, 0);
        run_slots(1);
        read_stats(0);
        read_stats(3);

        // MTU boundary, single-beat packets, TKEEP gap, out-of-range TDEST
        add_pkt(0, 3, MTU, exp_seq[3], -1, 0); run_slots(0);
        add_pkt(0, 3, MTU + 1, exp_seq[3], -1, 0); run_slots(0);
        add_pkt(0, 1, 1, exp_seq[1], -1, 0); run_slots(0);
        add_pkt(0, 2, DB, exp_seq[2], -1, 0); run_slots(0);
        add_pkt(0, 0, 40, exp_seq[0], -1, 3); run_slots(0);
        add_pkt(0, 9, 30, 0, -1, 0); run_slots(0);
        for (int d = 0; d < NCH; d++) read_stats(d);

        // clear_stats in the same cycle as a counting TLAST
        clear_on_last = 1;
        add_pkt(0, 1, 16, exp_seq[1], -1, 0); run_slots(0);
        clear_on_last = 0;
        for (int d = 0; d < NCH; d++) read_stats(d);

        // reset in the middle of a channel 0 packet
        add_pkt(0, 0, 64, exp_seq[0], -1, 0);
        for (int i = 0; i < 3; i++) drive(qa.pop_front());
        reset_dut();
        add_pkt(0, 0, 64, 0, -1, 0); run_slots(0);
        read_stats(0);

        // randomized mix, sometimes two channels interleaved
        repeat (250) begin
            gen_pkt(0, -1, da);
            if ($urandom_range(0, 1) == 1) gen_pkt(1, da, db);
            run_slots(0);
        end
        for (int d = 0; d < NCH; d++) read_stats(d);
        check_eq("err_pulse_total", seen_pulses, exp_pulses);
`ifdef AXIS_PKT_CHECKER_BP_EN
        check_eq("tready_low_run_bounded", run_max <= int'(max_bp_cycles), 1);
`else
        check_eq("tready_low_run", run_max, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
